// File: rtl/register_file_pkg.sv
// Shared constants and bus-slicing helpers for the multiport register file.
// Imported by the top level and the busy-bit scoreboard.
package register_file_pkg;

  localparam int unsigned ZERO_INDEX = 0;

  // Number of architectural registers addressed by an index of the given width.
  function automatic int unsigned reg_count(input int unsigned depth);
    return 32'd1 << depth;
  endfunction

  // Low bit of port p inside a flattened per-port bus of slices that are width bits wide.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Busy-bit scoreboard for registers awaiting a late (multi-cycle) writeback.
// A reservation beats a same-cycle clear of the same index; busy_count tracks the popcount.
module register_scoreboard
  import register_file_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reserve_enable,
  input  logic [DEPTH-1:0]            reserve_index,
  input  logic                        clear_enable,
  input  logic [DEPTH-1:0]            clear_index,
  output logic [reg_count(DEPTH)-1:0] busy,
  output logic [DEPTH:0]              busy_count
);

  logic reserve_valid;
  logic clear_valid;
  logic count_up;
  logic count_down;

  assign reserve_valid = reserve_enable && (reserve_index != DEPTH'(ZERO_INDEX));
  assign clear_valid   = clear_enable && (clear_index != DEPTH'(ZERO_INDEX)) &&
                         !(reserve_valid && (reserve_index == clear_index));
  // Count moves only on real 0->1 or 1->0 transitions, so it never wraps.
  assign count_up      = reserve_valid && !busy[reserve_index];
  assign count_down    = clear_valid && busy[clear_index];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (reserve_valid) busy[reserve_index] <= 1'b1;
      if (clear_valid)   busy[clear_index]   <= 1'b0;
      if (count_up && !count_down)      busy_count <= busy_count + (DEPTH+1)'(1);
      else if (count_down && !count_up) busy_count <= busy_count - (DEPTH+1)'(1);
    end
  end

endmodule

// File: rtl/register_file_multiport.sv
// General-purpose register file: N combinational read ports with write bypass,
// a pipeline and a late write port, collision flag and busy-bit scoreboard.
module register_file_multiport
  import register_file_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int READ_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [READ_PORTS-1:0]       read_enable,
  input  logic [READ_PORTS*DEPTH-1:0] read_index,
  output logic [READ_PORTS*WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]       read_busy,
  input  logic                        write_enable_0,
  input  logic [DEPTH-1:0]            write_index_0,
  input  logic [WIDTH-1:0]            write_data_0,
  input  logic                        write_enable_1,
  input  logic [DEPTH-1:0]            write_index_1,
  input  logic [WIDTH-1:0]            write_data_1,
  input  logic                        reserve_enable,
  input  logic [DEPTH-1:0]            reserve_index,
  output logic [DEPTH:0]              busy_count,
  output logic                        write_collision
);

  localparam int REGS = reg_count(DEPTH);

  logic [WIDTH-1:0] regs_q [REGS];
  logic [REGS-1:0]  busy;
  logic             valid_0;
  logic             valid_1;
  logic             same_index;

  assign valid_0    = write_enable_0 && (write_index_0 != DEPTH'(ZERO_INDEX));
  assign valid_1    = write_enable_1 && (write_index_1 != DEPTH'(ZERO_INDEX));
  assign same_index = write_index_0 == write_index_1;

  // NOTE: the array is reset on purpose -- software relies on every register reading 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
      write_collision <= 1'b0;
    end else begin
      if (valid_0) regs_q[write_index_0] <= write_data_0;
      // Port 0 (pipeline writeback) wins a same-index collision.
      if (valid_1 && !(valid_0 && same_index)) regs_q[write_index_1] <= write_data_1;
      write_collision <= valid_0 && valid_1 && same_index;
    end
  end

  register_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .reserve_enable (reserve_enable),
    .reserve_index  (reserve_index),
    .clear_enable   (write_enable_1),
    .clear_index    (write_index_1),
    .busy           (busy),
    .busy_count     (busy_count)
  );

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [DEPTH-1:0] index;
    logic [WIDTH-1:0] data;

    assign index = read_index[slice_lo(p, DEPTH) +: DEPTH];

    // NOTE: default assigned first so no path through the block leaves data unassigned (no latch).
    always_comb begin
      data = '0;
      if (read_enable[p] && (index != DEPTH'(ZERO_INDEX))) begin
        if (valid_0 && (write_index_0 == index))      data = write_data_0;
        else if (valid_1 && (write_index_1 == index)) data = write_data_1;
        else                                          data = regs_q[index];
      end
    end

    assign read_data[slice_lo(p, WIDTH) +: WIDTH] = data;
    // A same-cycle late write already counts as delivered.
    assign read_busy[p] = read_enable[p] && busy[index] &&
                          !(write_enable_1 && (write_index_1 == index));
  end

endmodule
